// File: rtl/anahtar_genisletme.sv
// rtl/anahtar_genisletme.sv - AES-128 key-schedule controller with a registered round-key table read port
//
// Steps one combinational round-key generator (tur_uret) through rounds
// 0..TUR_SAYISI-1 and stores all round keys in an internal table.
//
// Optional build macro: ANAHTAR_SIFIRLA_EN adds the synchronous zeroize input
// 'sifirla', which has priority over baslat.
//
// Parameters:
//   TUR_SAYISI   number of expansion rounds (10, AES-128 only)
//   ADIM_CEVRIM  clock cycles spent per round (>= 1)
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   sifirla        synchronous zeroize (only with ANAHTAR_SIFIRLA_EN)
//   baslat         start pulse, sampled while mesgul=0
//   anahtar        128-bit cipher key, sampled with baslat
//   mesgul         expansion in progress
//   hazir          all round keys valid
//   okuma_adr      round-key index to read, 0..10
//   okuma_anahtar  registered round key at okuma_adr
//   okuma_gecerli  okuma_anahtar holds a valid key
module anahtar_genisletme #(
    parameter int TUR_SAYISI  = 10,
    parameter int ADIM_CEVRIM = 1
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef ANAHTAR_SIFIRLA_EN
    input  logic         sifirla,
`endif
    input  logic         baslat,
    input  logic [127:0] anahtar,
    output logic         mesgul,
    output logic         hazir,
    input  logic [3:0]   okuma_adr,
    output logic [127:0] okuma_anahtar,
    output logic         okuma_gecerli
);

    localparam int SW = (ADIM_CEVRIM > 1) ? $clog2(ADIM_CEVRIM) : 1;

    // S-box, byte 0 is the leftmost byte of the constant
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        BOS      = 2'd0,
        GENISLET = 2'd1,
        TAMAM    = 2'd2
    } durum_t;

    function automatic logic [7:0] sub_bayt(input logic [7:0] b);
        return SBOX[int'(b) * 8 +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] tur);
        case (tur)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Single-round AES-128 key generator: round key tur -> round key tur+1
    function automatic logic [127:0] tur_uret(input logic [3:0] tur, input logic [127:0] k);
        logic [31:0] temp;
        logic [31:0] n0, n1, n2, n3;
        // RotWord then SubWord on the last word, Rcon into the top byte
        temp = {sub_bayt(k[23:16]), sub_bayt(k[15:8]), sub_bayt(k[7:0]), sub_bayt(k[31:24])}
               ^ {rcon(tur), 24'h000000};
        n0 = k[127:96] ^ temp;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    durum_t         r_durum;
    logic [127:0]   r_tablo [0:TUR_SAYISI];
    logic [TUR_SAYISI:0] r_gecerli;
    logic [3:0]     r_tur;
    logic [SW-1:0]  r_adim;
    logic           r_mesgul;
    logic           r_hazir;
    logic [127:0]   r_okuma_anahtar;
    logic           r_okuma_gecerli;

    logic [127:0]   w_sonraki;
    logic           w_son_adim;
    logic           w_okuma_izin;

    assign w_sonraki    = tur_uret(r_tur, r_tablo[r_tur]);
    assign w_son_adim   = (r_adim == SW'(ADIM_CEVRIM - 1));
    assign w_okuma_izin = (okuma_adr <= 4'(TUR_SAYISI)) && r_gecerli[okuma_adr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_durum         <= BOS;
            r_gecerli       <= '0;
            r_tur           <= '0;
            r_adim          <= '0;
            r_mesgul        <= 1'b0;
            r_hazir         <= 1'b0;
            r_okuma_anahtar <= '0;
            r_okuma_gecerli <= 1'b0;
            for (int i = 0; i <= TUR_SAYISI; i++) begin
                r_tablo[i] <= '0;
            end
        end
`ifdef ANAHTAR_SIFIRLA_EN
        else if (sifirla) begin
            r_durum         <= BOS;
            r_gecerli       <= '0;
            r_tur           <= '0;
            r_adim          <= '0;
            r_mesgul        <= 1'b0;
            r_hazir         <= 1'b0;
            r_okuma_anahtar <= '0;
            r_okuma_gecerli <= 1'b0;
            for (int i = 0; i <= TUR_SAYISI; i++) begin
                r_tablo[i] <= '0;
            end
        end
`endif
        else begin
            // Read port sees the pre-edge table: an entry written on this
            // same edge is still returned as invalid.
            if (w_okuma_izin) begin
                r_okuma_anahtar <= r_tablo[okuma_adr];
                r_okuma_gecerli <= 1'b1;
            end else begin
                r_okuma_anahtar <= '0;
                r_okuma_gecerli <= 1'b0;
            end

            case (r_durum)
                BOS, TAMAM: begin
                    if (baslat) begin
                        r_tablo[0]   <= anahtar;
                        r_gecerli    <= {{TUR_SAYISI{1'b0}}, 1'b1};
                        r_tur        <= '0;
                        r_adim       <= '0;
                        r_mesgul     <= 1'b1;
                        r_hazir      <= 1'b0;
                        r_durum      <= GENISLET;
                    end
                end
                GENISLET: begin
                    if (w_son_adim) begin
                        r_tablo[r_tur + 4'd1]   <= w_sonraki;
                        r_gecerli[r_tur + 4'd1] <= 1'b1;
                        r_adim                  <= '0;
                        if (r_tur == 4'(TUR_SAYISI - 1)) begin
                            // tur holds at the last round so the generator
                            // index never runs past the table
                            r_mesgul <= 1'b0;
                            r_hazir  <= 1'b1;
                            r_durum  <= TAMAM;
                        end else begin
                            r_tur <= r_tur + 4'd1;
                        end
                    end else begin
                        r_adim <= r_adim + 1'b1;
                    end
                end
                default: begin
                    r_durum <= BOS;
                end
            endcase
        end
    end

    assign mesgul        = r_mesgul;
    assign hazir         = r_hazir;
    assign okuma_anahtar = r_okuma_anahtar;
    assign okuma_gecerli = r_okuma_gecerli;

endmodule

// File: tb/tb_anahtar_genisletme.sv
// tb/tb_anahtar_genisletme.sv - self-checking bench for anahtar_genisletme (ADIM_CEVRIM 1 and 3)
module tb_anahtar_genisletme;

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         baslat;
    logic [127:0] anahtar;
    logic [3:0]   okuma_adr;
`ifdef ANAHTAR_SIFIRLA_EN
    logic         sifirla;
`endif

    logic         mesgul1, hazir1, gec1;
    logic [127:0] ok1;
    logic         mesgul3, hazir3, gec3;
    logic [127:0] ok3;

    always #5 clk = ~clk;

    anahtar_genisletme #(.TUR_SAYISI(10), .ADIM_CEVRIM(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
`ifdef ANAHTAR_SIFIRLA_EN
        .sifirla(sifirla),
`endif
        .baslat(baslat), .anahtar(anahtar),
        .mesgul(mesgul1), .hazir(hazir1),
        .okuma_adr(okuma_adr), .okuma_anahtar(ok1), .okuma_gecerli(gec1)
    );

    anahtar_genisletme #(.TUR_SAYISI(10), .ADIM_CEVRIM(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
`ifdef ANAHTAR_SIFIRLA_EN
        .sifirla(sifirla),
`endif
        .baslat(baslat), .anahtar(anahtar),
        .mesgul(mesgul3), .hazir(hazir3),
        .okuma_adr(okuma_adr), .okuma_anahtar(ok3), .okuma_gecerli(gec3)
    );

    typedef struct {
        string        etiket;
        logic [128:0] deger;
    } beklenti_t;

    beklenti_t sb[$];
    int n_vektor = 0;
    int n_hata   = 0;
    int cyc      = 0;
    int t0       = 0;
    int lat1, lat3;

    task automatic kontrol(input string etiket, input logic [128:0] gozlenen, input logic [128:0] beklenen);
        n_vektor++;
        if (gozlenen !== beklenen) begin
            n_hata++;
            $display("FAIL %s: got %h expected %h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Push the expected read result, clock the registered read port, pop and compare
    task automatic oku(input bit sec3, input logic [3:0] adr, input logic g, input logic [127:0] k, input string etiket);
        beklenti_t b;
        okuma_adr = adr;
        sb.push_back('{etiket, {g, k}});
        tick();
        b = sb.pop_front();
        kontrol(b.etiket, sec3 ? {gec3, ok3} : {gec1, ok1}, b.deger);
    endtask

    task automatic baslat_ver(input logic [127:0] k);
        baslat  = 1'b1;
        anahtar = k;
        tick();
        baslat  = 1'b0;
        t0      = cyc;
    endtask

    // Latencies are counted in edges from the baslat sampling edge
    task automatic bekle();
        lat1 = -1;
        lat3 = -1;
        while ((lat1 < 0 || lat3 < 0) && (cyc - t0) < 100) begin
            if (hazir1 && lat1 < 0) lat1 = cyc - t0;
            if (hazir3 && lat3 < 0) lat3 = cyc - t0;
            if (lat1 < 0 || lat3 < 0) tick();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        baslat    = 1'b0;
        anahtar   = '0;
        okuma_adr = '0;
`ifdef ANAHTAR_SIFIRLA_EN
        sifirla   = 1'b0;
`endif
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state and empty table on every address
        kontrol("rst_mesgul", 129'(mesgul1), 129'd0);
        kontrol("rst_hazir", 129'(hazir1), 129'd0);
        kontrol("rst_mesgul3", 129'(mesgul3), 129'd0);
        for (int a = 0; a < 16; a++) begin
            oku(1'b0, 4'(a), 1'b0, 128'd0, $sformatf("rst_adr%0d", a));
        end

        // FIPS-197 key on both step settings
        baslat_ver(K1);
        kontrol("k1_mesgul", 129'(mesgul1), 129'd1);
        bekle();
        kontrol("k1_lat1", 129'(lat1), 129'd10);
        kontrol("k1_lat3", 129'(lat3), 129'd30);
        oku(1'b0, 4'd1,  1'b1, K1_R1,  "k1_adr1");
        oku(1'b0, 4'd10, 1'b1, K1_R10, "k1_adr10");
        oku(1'b0, 4'd0,  1'b1, K1,     "k1_adr0");
        oku(1'b0, 4'd11, 1'b0, 128'd0, "k1_adr11");
        oku(1'b0, 4'd15, 1'b0, 128'd0, "k1_adr15");
        oku(1'b1, 4'd1,  1'b1, K1_R1,  "k1s3_adr1");
        oku(1'b1, 4'd10, 1'b1, K1_R10, "k1s3_adr10");
        oku(1'b1, 4'd0,  1'b1, K1,     "k1s3_adr0");

        // Restart from TAMAM, reads during expansion, ignored busy start
        baslat_ver(K1);
        kontrol("rs_hazir_drop", 129'(hazir1), 129'd0);
        kontrol("rs_mesgul", 129'(mesgul1), 129'd1);
        tick();
        tick();
        oku(1'b0, 4'd2, 1'b1, K1_R2,  "mid_adr2");
        oku(1'b0, 4'd4, 1'b0, 128'd0, "mid_adr4_same_edge");
        oku(1'b0, 4'd5, 1'b0, 128'd0, "mid_adr5");
        baslat  = 1'b1;
        anahtar = K2;
        tick();
        baslat  = 1'b0;
        kontrol("busy_mesgul", 129'(mesgul1), 129'd1);
        bekle();
        kontrol("busy_lat1", 129'(lat1), 129'd10);
        oku(1'b0, 4'd10, 1'b1, K1_R10, "busy_adr10");
        oku(1'b0, 4'd0,  1'b1, K1,     "busy_adr0");

        // Second key
        baslat_ver(K2);
        bekle();
        kontrol("k2_lat1", 129'(lat1), 129'd10);
        oku(1'b0, 4'd10, 1'b1, K2_R10, "k2_adr10");
        oku(1'b0, 4'd0,  1'b1, K2,     "k2_adr0");
        oku(1'b1, 4'd10, 1'b1, K2_R10, "k2s3_adr10");

        // Asynchronous reset mid-expansion
        okuma_adr = 4'd0;
        baslat_ver(K1);
        tick();
        tick();
        tick();
        tick();
        kontrol("pre_rst_gec", 129'(gec1), 129'd1);
        rst_n = 1'b0;
        #1;
        kontrol("arst_outs", {mesgul1, hazir1, gec1, ok1[125:0]}, 129'd0);
        kontrol("arst_ok", 129'(ok1), 129'd0);
        tick();
        rst_n = 1'b1;
        oku(1'b0, 4'd1, 1'b0, 128'd0, "arst_adr1");
        oku(1'b0, 4'd0, 1'b0, 128'd0, "arst_adr0");

`ifdef ANAHTAR_SIFIRLA_EN
        baslat_ver(K1);
        bekle();
        sifirla = 1'b1;
        tick();
        sifirla = 1'b0;
        kontrol("zr_hazir", 129'(hazir1), 129'd0);
        kontrol("zr_mesgul", 129'(mesgul1), 129'd0);
        oku(1'b0, 4'd0, 1'b0, 128'd0, "zr_adr0");
        baslat_ver(K1);
        bekle();
        kontrol("zr_lat1", 129'(lat1), 129'd10);
        oku(1'b0, 4'd10, 1'b1, K1_R10, "zr_adr10");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vektor, n_hata);
        $finish;
    end

endmodule
